// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the issuing units and alu_share_arb.
// rsp_zero exists only when ALU_SHARE_ZFLAG_EN is defined.
interface alu_share_arb_if #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*6-1:0]     req_fn;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err;
`ifdef ALU_SHARE_ZFLAG_EN
   logic                  rsp_zero;

   modport master (
      output req_valid, req_a, req_b, req_fn, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, rsp_zero
   );
   modport slave (
      input  req_valid, req_a, req_b, req_fn, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, rsp_zero
   );
`else
   modport master (
      output req_valid, req_a, req_b, req_fn, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );
   modport slave (
      input  req_valid, req_a, req_b, req_fn, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );
`endif
endinterface

// File: rtl/alu_share_arb.sv
// One ALU shared by NREQ requesters: round-robin accept, one execute cycle, held tagged response.
// Optional result-is-zero flag on rsp_zero when ALU_SHARE_ZFLAG_EN is defined.
module alu_share_arb #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4
) (
   input logic           clk,
   input logic           rst_n,
   alu_share_arb_if.slave bus
);
   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state;
   logic [IDW-1:0]    last;
   logic [NREQ-1:0]   grant;
   logic [IDW-1:0]    gid;
   logic              gvld;
   int                best;

   logic [WIDTH-1:0]  a_sel, b_sel;
   logic [5:0]        fn_sel;
   logic [WIDTH-1:0]  a_p0, b_p0;
   logic [5:0]        fn_p0;
   logic [IDW-1:0]    id_p0;

   logic signed [WIDTH-1:0] sa_p0, sb_p0;
   logic [3:0]        tt_p0;
   logic [WIDTH-1:0]  alu_y;
   logic              alu_ill;
   logic [WIDTH-1:0]  res_p1;

   // Distance of candidate i behind the last winner in the rotating priority order.
   function automatic int rr_dist(input int i, input logic [IDW-1:0] l);
      return (i > int'(l)) ? (i - int'(l) - 1) : (i + NREQ - int'(l) - 1);
   endfunction

   function automatic logic [WIDTH-1:0] mask_illegal(input logic [WIDTH-1:0] y, input logic ill);
      return ill ? '0 : y;
   endfunction

   always_comb begin
      gid  = '0;
      gvld = 1'b0;
      best = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req_valid[i] && (rr_dist(i, last) < best)) begin
            best = rr_dist(i, last);
            gid  = IDW'(i);
            gvld = 1'b1;
         end
      end
      grant = (state == IDLE && gvld) ? (NREQ'(1) << gid) : '0;
   end

   assign bus.req_ready = grant;

   always_comb begin
      a_sel  = '0;
      b_sel  = '0;
      fn_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            a_sel  = bus.req_a[i*WIDTH +: WIDTH];
            b_sel  = bus.req_b[i*WIDTH +: WIDTH];
            fn_sel = bus.req_fn[i*6 +: 6];
         end
      end
   end

   // p0: operands captured at accept
   always_ff @(posedge clk) begin
      if (|grant) begin
         a_p0  <= a_sel;
         b_p0  <= b_sel;
         fn_p0 <= fn_sel;
         id_p0 <= gid;
      end
   end

   assign sa_p0 = signed'(a_p0);
   assign sb_p0 = signed'(b_p0);
   assign tt_p0 = fn_p0[3:0];

   // Shared ALU, fed only from the latched operands
   always_comb begin
      alu_y   = '0;
      alu_ill = 1'b0;
      case (fn_p0[5:4])
         2'b00: begin
            case (fn_p0[2:1])
               2'b01:   alu_y = WIDTH'(a_p0 == b_p0);
               2'b10:   alu_y = WIDTH'(sa_p0 < sb_p0);
               2'b11:   alu_y = WIDTH'(sa_p0 <= sb_p0);
               default: alu_ill = 1'b1;
            endcase
         end
         2'b01: alu_y = fn_p0[0] ? (a_p0 - b_p0) : (a_p0 + b_p0);
         2'b10: begin
            for (int i = 0; i < WIDTH; i++) alu_y[i] = tt_p0[{b_p0[i], a_p0[i]}];
         end
         default: begin
            case (fn_p0[1:0])
               2'b00:   alu_y = a_p0 << b_p0;
               2'b01:   alu_y = a_p0 >> b_p0;
               2'b11:   alu_y = sa_p0 >>> b_p0;
               default: alu_ill = 1'b1;
            endcase
         end
      endcase
   end

   assign res_p1 = mask_illegal(alu_y, alu_ill);

   // p1: registered, tagged response held until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         last          <= IDW'(NREQ - 1);
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_id    <= '0;
         bus.rsp_err   <= 1'b0;
`ifdef ALU_SHARE_ZFLAG_EN
         bus.rsp_zero  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (gvld) begin
                  last  <= gid;
                  state <= EXEC;
               end
            end
            EXEC: begin
               bus.rsp_data  <= res_p1;
               bus.rsp_id    <= id_p0;
               bus.rsp_err   <= alu_ill;
`ifdef ALU_SHARE_ZFLAG_EN
               bus.rsp_zero  <= ~|res_p1;
`endif
               bus.rsp_valid <= 1'b1;
               state         <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: reference round-robin + ALU model, directed and random stimulus.
module tb_alu_share_arb;
   localparam int WIDTH = 32;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_share_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus();
   alu_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got no event expected one within budget", name);
   endtask

   // Reference ALU from the function-code rules; returns {err, data}.
   function automatic logic [32:0] ref_alu(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic e;
      r = 32'd0;
      e = 1'b0;
      case (fn[5:4])
         2'd0: case (fn[2:1])
                  2'd1:    r = (a == b) ? 32'd1 : 32'd0;
                  2'd2:    r = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
                  2'd3:    r = ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
                  default: e = 1'b1;
               endcase
         2'd1: r = fn[0] ? a - b : a + b;
         2'd2: r = (~a & ~b & {32{fn[0]}}) | (a & ~b & {32{fn[1]}}) |
                   (~a & b & {32{fn[2]}}) | (a & b & {32{fn[3]}});
         default: case (fn[1:0])
                     2'd0:    r = (b >= 32) ? 32'd0 : a << b[4:0];
                     2'd1:    r = (b >= 32) ? 32'd0 : a >> b[4:0];
                     2'd3:    r = (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
                     default: e = 1'b1;
                  endcase
      endcase
      if (e) r = 32'd0;
      return {e, r};
   endfunction

   // Monitor / scoreboard
   int          q_id[$];
   logic [31:0] q_data[$];
   logic        q_err[$];
   int          m_last = NREQ - 1;
   bit          m_busy = 0;
   int          mcyc = 0;
   int          acc_cyc = 0;
   int          win, cand;
   logic [NREQ-1:0] exp_ready;
   logic [32:0] r;

   always @(negedge clk) begin
      mcyc++;
      if (!rst_n) begin
         m_busy = 0;
         m_last = NREQ - 1;
         q_id.delete();
         q_data.delete();
         q_err.delete();
         check("reset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
         check("reset_rsp_data", {32'd0, bus.rsp_data}, 64'd0);
         check("reset_rsp_id", {62'd0, bus.rsp_id}, 64'd0);
         check("reset_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
`ifdef ALU_SHARE_ZFLAG_EN
         check("reset_rsp_zero", {63'd0, bus.rsp_zero}, 64'd0);
`endif
      end else begin
         win = -1;
         exp_ready = '0;
         if (!m_busy) begin
            for (int k = 1; k <= NREQ; k++) begin
               cand = (m_last + k) % NREQ;
               if (win < 0 && bus.req_valid[cand]) win = cand;
            end
         end
         if (win >= 0) exp_ready[win] = 1'b1;
         check("req_ready", {60'd0, bus.req_ready}, {60'd0, exp_ready});
         check("rsp_valid_timing", {63'd0, bus.rsp_valid},
               {63'd0, (m_busy && (mcyc - acc_cyc >= 2))});
         if (bus.rsp_valid) begin
            if (q_id.size() == 0) begin
               timeout("rsp_unexpected");
            end else begin
               check("rsp_id", {62'd0, bus.rsp_id}, 64'(q_id[0]));
               check("rsp_data", {32'd0, bus.rsp_data}, {32'd0, q_data[0]});
               check("rsp_err", {63'd0, bus.rsp_err}, {63'd0, q_err[0]});
`ifdef ALU_SHARE_ZFLAG_EN
               check("rsp_zero", {63'd0, bus.rsp_zero}, {63'd0, (q_data[0] == 32'd0)});
`endif
               if (bus.rsp_ready) begin
                  void'(q_id.pop_front());
                  void'(q_data.pop_front());
                  void'(q_err.pop_front());
                  m_busy = 0;
               end
            end
         end
         if (win >= 0) begin
            r = ref_alu(bus.req_fn[win*6 +: 6], bus.req_a[win*WIDTH +: WIDTH], bus.req_b[win*WIDTH +: WIDTH]);
            q_id.push_back(win);
            q_data.push_back(r[31:0]);
            q_err.push_back(r[32]);
            m_busy  = 1;
            m_last  = win;
            acc_cyc = mcyc;
         end
      end
   end

   // Stimulus
   logic [NREQ-1:0] hs;
   logic [NREQ-1:0] s_ready;
   logic            s_rv;
   logic [31:0]     s_data;
   logic [IDW-1:0]  s_id;
   logic            s_err;
   logic            s_zero;
   int              cyc = 0;

   task automatic step();
      @(negedge clk);
      hs      = bus.req_valid & bus.req_ready;
      s_ready = bus.req_ready;
      s_rv    = bus.rsp_valid;
      s_data  = bus.rsp_data;
      s_id    = bus.rsp_id;
      s_err   = bus.rsp_err;
`ifdef ALU_SHARE_ZFLAG_EN
      s_zero  = bus.rsp_zero;
`else
      s_zero  = (bus.rsp_data == 32'd0);
`endif
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn);
      bus.req_a[i*WIDTH +: WIDTH] = a;
      bus.req_b[i*WIDTH +: WIDTH] = b;
      bus.req_fn[i*6 +: 6]        = fn;
      bus.req_valid[i]            = 1'b1;
   endtask

   task automatic rand_req(input int i);
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
         0:       b = 32'($urandom_range(0, 40));
         1:       b = a;
         default: b = $urandom;
      endcase
      set_req(i, a, b, 6'($urandom_range(0, 63)));
   endtask

   task automatic wait_hs(input int budget, input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (hs == '0 && n < budget);
      if (hs == '0) timeout(name);
   endtask

   task automatic wait_rsp(input int budget, input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!s_rv && n < budget);
      if (!s_rv) timeout(name);
   endtask

   task automatic run_one(input int i, input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn);
      set_req(i, a, b, fn);
      wait_hs(10, "op_accept");
      bus.req_valid[i] = 1'b0;
      wait_rsp(10, "op_response");
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   int          prev;
   logic [31:0] snap_d;
   logic [IDW-1:0] snap_id;

   initial begin
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_fn    = '0;
      bus.rsp_ready = 1'b1;

      repeat (3) step();
      rst_n = 1'b1;
      step();
      check("idle_no_ready", {60'd0, s_ready}, 64'd0);

      // Reset priority: requester 0 wins over 2
      set_req(0, 32'd5, 32'd7, 6'b010000);
      set_req(2, $urandom, $urandom, 6'b010000);
      step();
      check("prio_grant", {60'd0, hs}, 64'h1);
      bus.req_valid[0] = 1'b0;
      step();
      check("prio_exec_no_valid", {63'd0, s_rv}, 64'd0);
      step();
      check("prio_rsp_valid", {63'd0, s_rv}, 64'd1);
      check("prio_rsp_data", {32'd0, s_data}, 64'd12);
      check("prio_rsp_id", {62'd0, s_id}, 64'd0);
      step();
      check("prio_next_grant", {60'd0, hs}, 64'h4);
      bus.req_valid[2] = 1'b0;
      repeat (3) step();

      // Fairness from reset
      do_reset();
      for (int i = 0; i < NREQ; i++) rand_req(i);
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         wait_hs(20, "fair_wait");
         check("fair_grant", {60'd0, hs}, 64'(1 << (k % NREQ)));
         if (k > 0) check("fair_gap", 64'(cyc - prev), 64'd3);
         prev = cyc;
         for (int i = 0; i < NREQ; i++) if (hs[i]) rand_req(i);
      end
      bus.req_valid = '0;
      repeat (4) step();

      // Subtract and signed compare
      run_one(1, 32'd3, 32'd5, 6'b010001);
      check("sub_data", {32'd0, s_data}, 64'hFFFF_FFFE);
      check("sub_err", {63'd0, s_err}, 64'd0);
      step();
      run_one(3, 32'h8000_0000, 32'd1, 6'b000100);
      check("lt_data", {32'd0, s_data}, 64'd1);
      step();

      // Backpressure with requester 1 pending
      bus.rsp_ready = 1'b0;
      set_req(0, $urandom, $urandom, 6'b100110);
      wait_hs(10, "bp_accept0");
      bus.req_valid[0] = 1'b0;
      set_req(1, 32'd9, 32'd4, 6'b010000);
      step();
      step();
      check("bp_rsp_valid", {63'd0, s_rv}, 64'd1);
      snap_d  = s_data;
      snap_id = s_id;
      repeat (5) begin
         step();
         check("bp_req_ready", {60'd0, s_ready}, 64'd0);
         check("bp_hold_valid", {63'd0, s_rv}, 64'd1);
         check("bp_hold_data", {32'd0, s_data}, {32'd0, snap_d});
         check("bp_hold_id", {62'd0, s_id}, {62'd0, snap_id});
      end
      bus.rsp_ready = 1'b1;
      step();
      check("bp_release_no_accept", {60'd0, hs}, 64'd0);
      step();
      check("bp_accept1", {60'd0, hs}, 64'h2);
      bus.req_valid[1] = 1'b0;
      wait_rsp(10, "bp_rsp1");
      check("bp_rsp1_data", {32'd0, s_data}, 64'd13);
      step();

      // Illegal codes
      run_one(2, $urandom, $urandom, 6'b110010);
      check("ill_shift_data", {32'd0, s_data}, 64'd0);
      check("ill_shift_err", {63'd0, s_err}, 64'd1);
      check("ill_shift_zero", {63'd0, s_zero}, 64'd1);
      step();
      run_one(0, $urandom, $urandom, 6'b001001);
      check("ill_cmp_err", {63'd0, s_err}, 64'd1);
      check("ill_cmp_data", {32'd0, s_data}, 64'd0);
      step();

      // Randomised traffic with drops and backpressure
      for (int c = 0; c < 3000; c++) begin
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
               if ($urandom_range(0, 1) == 1) rand_req(i);
               else bus.req_valid[i] = 1'b0;
            end else if (!bus.req_valid[i]) begin
               if ($urandom_range(0, 3) == 0) rand_req(i);
            end else if ($urandom_range(0, 15) == 0) begin
               bus.req_valid[i] = 1'b0;
            end
         end
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (5) step();

      // Reset during EXEC
      set_req(2, $urandom, $urandom, 6'b010000);
      wait_hs(10, "midrst_accept");
      rst_n = 1'b0;
      step();
      check("midrst_valid_in_reset", {63'd0, s_rv}, 64'd0);
      bus.req_valid[2] = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (3) begin
         step();
         check("midrst_no_response", {63'd0, s_rv}, 64'd0);
      end
      for (int i = 0; i < NREQ; i++) rand_req(i);
      step();
      check("midrst_last_restored", {60'd0, hs}, 64'h1);
      bus.req_valid = '0;
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end
endmodule
